// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner and its decoder.
package seven_seg_pkg;

    typedef logic [3:0] hex_nibble_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bit positions of each segment inside the packed seg_n bus.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    function automatic int cnt_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex.sv
// hexConverter: combinational hex-to-7-segment decoder, active-low a..g outputs.
module hexConverter
    import seven_seg_pkg::*;
(
    input  hex_nibble_t hex_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        e_o,
    output logic        f_o,
    output logic        g_o
);

    logic [6:0] pattern;

    always_comb begin
        unique case (hex_i)
            4'h0:    pattern = 7'h01;
            4'h1:    pattern = 7'h4F;
            4'h2:    pattern = 7'h12;
            4'h3:    pattern = 7'h06;
            4'h4:    pattern = 7'h4C;
            4'h5:    pattern = 7'h24;
            4'h6:    pattern = 7'h20;
            4'h7:    pattern = 7'h0F;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h04;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h60;
            4'hC:    pattern = 7'h31;
            4'hD:    pattern = 7'h42;
            4'hE:    pattern = 7'h30;
            default: pattern = 7'h38;
        endcase
    end

    assign a_o = pattern[SEG_A];
    assign b_o = pattern[SEG_B];
    assign c_o = pattern[SEG_C];
    assign d_o = pattern[SEG_D];
    assign e_o = pattern[SEG_E];
    assign f_o = pattern[SEG_F];
    assign g_o = pattern[SEG_G];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with blanking guard and frame-synchronous value update.
// Build option: SEVEN_SEG_LEADING_ZERO_BLANK_EN darkens leading-zero digits above digit 0.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_done_q, frame_done_d;

    hex_nibble_t             cur_nibble;
    logic                    cur_dp;
    logic                    cur_shown;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic [NUM_DIGITS-1:0]   show_mask;
    logic                    at_boundary;
    logic [6:0]              dec_seg;

    assign at_boundary = enable && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic nz_above;

    // Scan from the top digit down; a digit lights once any nibble at or above it is nonzero.
    always_comb begin
        nz_above  = 1'b0;
        show_mask = digit_en;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            nz_above = nz_above | (active_q[4*k +: 4] != 4'h0);
            if (!nz_above) begin
                show_mask[k] = 1'b0;
            end
        end
    end
`else
    assign show_mask = digit_en;
`endif

    // NOTE: every always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_shown  = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nibble    = active_q[4*k +: 4];
                cur_dp        = dp_in[k];
                cur_shown     = show_mask[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    hexConverter u_hex (
        .hex_i (cur_nibble),
        .a_o   (dec_seg[SEG_A]),
        .b_o   (dec_seg[SEG_B]),
        .c_o   (dec_seg[SEG_C]),
        .d_o   (dec_seg[SEG_D]),
        .e_o   (dec_seg[SEG_E]),
        .f_o   (dec_seg[SEG_F]),
        .g_o   (dec_seg[SEG_G])
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
                ST_SHOW:  if (cnt_q == CNT_LAST)   state_d = ST_BLANK;
                default:  state_d = ST_BLANK;
            endcase
        end
    end

    always_comb begin
        an_n_d       = '1;
        seg_n_d      = SEG_OFF;
        dp_n_d       = 1'b1;
        frame_done_d = 1'b0;
        if (enable) begin
            frame_done_d = at_boundary;
            if (state_q == ST_SHOW) begin
                seg_n_d = dec_seg;
                dp_n_d  = ~cur_dp;
                if (cur_shown) begin
                    an_n_d = ~cur_onehot;
                end
            end
        end
    end

    // A load on the boundary bypasses the pending buffer so the next frame already shows it.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (load) begin
            pending_d = value_in;
            if (at_boundary) begin
                active_d        = value_in;
                pending_valid_d = 1'b0;
            end else begin
                pending_valid_d = 1'b1;
            end
        end else if (at_boundary && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_BLANK;
            cnt_q           <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            an_n_q          <= '1;
            seg_n_q         <= SEG_OFF;
            dp_n_q          <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            an_n_q          <= an_n_d;
            seg_n_q         <= seg_n_d;
            dp_n_q          <= dp_n_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed phases plus random traffic against a frame-position model.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = N * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [4*N-1:0] value_in = '0;
    logic          load = 1'b0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  digit_en = '1;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [N-1:0]  an_n;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;

    // Model state: position inside the frame in enabled cycles, plus the two value buffers.
    int          pos = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    bit          m_pv = 1'b0;

    // Lit segments (abcdefg, active high) for each hex digit.
    logic [6:0] seg_on [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, observed, expected, pos);
        end
    endtask

    task automatic model_reset();
        pos       = 0;
        m_active  = '0;
        m_pending = '0;
        m_pv      = 1'b0;
    endtask

    // One clock: predict outputs from the current inputs and model, advance, then compare.
    task automatic step();
        int          d;
        int          off;
        logic [3:0]  mask;
        logic [3:0]  nib;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fd;
        bit          boundary;

        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (enable) begin
            d    = pos / R;
            off  = pos % R;
            mask = digit_en;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            for (int k = 1; k < N; k++) begin
                if ((m_active >> (4 * k)) == 16'h0) mask[k] = 1'b0;
            end
`endif
            if (off >= B) begin
                nib   = m_active[4*d +: 4];
                e_seg = ~seg_on[nib];
                e_dp  = ~dp_in[d];
                if (mask[d]) e_an = ~(4'b0001 << d);
            end
            e_fd = (pos == FRAME - 1);
        end

        boundary = enable && (pos == FRAME - 1);
        if (load) begin
            m_pending = value_in;
            if (boundary) begin
                m_active = value_in;
                m_pv     = 1'b0;
            end else begin
                m_pv = 1'b1;
            end
        end else if (boundary && m_pv) begin
            m_active = m_pending;
            m_pv     = 1'b0;
        end
        if (enable) pos = (pos + 1) % FRAME;

        @(posedge clk);
        #1;
        check("an_n", an_n, e_an);
        check("seg_n", seg_n, e_seg);
        check("dp_n", dp_n, e_dp);
        check("frame_done", frame_done, e_fd);
        if (frame_done) fd_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_step(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Advance until the model reaches the target position; bounded by two frames.
    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FRAME && pos != target; i++) step();
        check("run_to_bound", pos, target);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check("rst_an_n", an_n, 4'hF);
        check("rst_seg_n", seg_n, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // First frame shows zeros, then 1234 from the following frame
        enable   = 1'b1;
        digit_en = 4'hF;
        dp_in    = 4'b0000;
        load_step(16'h1234);
        run(FRAME + 8);

        // Steady scan: two frame_done pulses per 64 cycles
        fd_seen = 0;
        run(2 * FRAME);
        check("frame_done_per_64", fd_seen, 2);

        // Two loads in one frame, last wins
        run_to(3);
        load_step(16'hAAAA);
        run(5);
        load_step(16'h5555);
        run(2 * FRAME);

        // Load on the boundary cycle commits straight to active
        run_to(FRAME - 1);
        load_step(16'h9876);
        run(FRAME + 4);

        // Digit 2 masked; frame length unchanged
        digit_en = 4'b1011;
        dp_in    = 4'b0101;
        fd_seen  = 0;
        run(2 * FRAME);
        check("masked_frame_done_per_64", fd_seen, 2);
        digit_en = 4'hF;

        // Enable dropped mid-slot for 20 cycles, with a load while dark
        run_to(R + 4);
        enable  = 1'b0;
        fd_seen = 0;
        run(6);
        load_step(16'hC0DE);
        run(13);
        check("no_frame_done_while_disabled", fd_seen, 0);
        enable = 1'b1;
        run(FRAME + 8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            dp_in  = N'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = N'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                value_in = 16'($urandom) >> $urandom_range(0, 15);
                load     = 1'b1;
            end
            step();
            load = 1'b0;
        end
        enable   = 1'b1;
        digit_en = 4'hF;
        dp_in    = 4'b0000;

        // Reset asserted in the middle of a SHOW window
        load_step(16'h4321);
        run_to(2 * R + 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_an_n", an_n, 4'hF);
        check("async_rst_seg_n", seg_n, 7'h7F);
        check("async_rst_dp_n", dp_n, 1'b1);
        check("async_rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Active and pending cleared: zeros for two frames with no load
        value_in = 16'hFFFF;
        run(2 * FRAME);

        // Leading-zero value
        load_step(16'h0040);
        run(2 * FRAME + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
